// File: rtl/shifter_defs.sv
// Shared definitions for the shifter arbiter slice.
// Holds the shift-direction encodings, the round-robin priority
// encodings and the default datapath widths.
package shifter_defs;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

endpackage

// File: rtl/barrel_shifter32.sv
// Combinational logical barrel shifter.
// Ports:
//   data_in  - operand
//   shamt    - shift amount (0 passes the operand through)
//   dir      - DIR_LEFT / DIR_RIGHT, zero fill on both sides
//   data_out - shifted result
module barrel_shifter32
    import shifter_defs::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic [WIDTH-1:0]   data_out
);

    always_comb begin
        data_out = '0;
        if (dir == DIR_LEFT) begin
            data_out = data_in << shamt;
        end else begin
            data_out = data_in >> shamt;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with registered priority.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   eligible   - per-requester eligibility this cycle
//   grant      - one-hot (or zero) grant, combinational from eligible/pri
module rr_arb2
    import shifter_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    pri_e pri_q, pri_d;

    always_comb begin
        grant = 2'b00;
        pri_d = pri_q;
        // A lone eligible requester always wins; pri only breaks ties.
        if (eligible == 2'b11) begin
            grant = (pri_q == PRI0) ? 2'b01 : 2'b10;
        end else begin
            grant = eligible;
        end
        if (grant[0]) begin
            pri_d = PRI1;
        end else if (grant[1]) begin
            pri_d = PRI0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_q <= PRI0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Shares one barrel shifter between two valid/ready requesters.
// Round-robin grant, at most one shift per cycle, and a one-entry
// registered response buffer per requester.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   reqN_valid/ready       - request handshake for requester N
//   reqN_data/shamt/dir    - operand, shift amount, direction
//   respN_valid/ready/data - buffered result handshake for requester N
module shifter_arbiter
    import shifter_defs::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req0_dir,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic [WIDTH-1:0]   resp0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic               req1_dir,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic [WIDTH-1:0]   resp1_data
);

    logic [1:0]         eligible;
    logic [1:0]         grant;
    logic [WIDTH-1:0]   sh_data_in;
    logic [SHAMT_W-1:0] sh_shamt;
    logic               sh_dir;
    logic [WIDTH-1:0]   sh_data_out;

    logic               resp0_valid_q, resp0_valid_d;
    logic               resp1_valid_q, resp1_valid_d;
    logic [WIDTH-1:0]   resp0_data_q, resp0_data_d;
    logic [WIDTH-1:0]   resp1_data_q, resp1_data_d;

    // A full buffer still accepts when it is being drained in the same
    // cycle. Eligibility is masked during reset so no ready is raised.
    always_comb begin
        eligible    = 2'b00;
        eligible[0] = req0_valid & (~resp0_valid_q | resp0_ready) & ~reset;
        eligible[1] = req1_valid & (~resp1_valid_q | resp1_ready) & ~reset;
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .grant    (grant)
    );

    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        sh_data_in = '0;
        sh_shamt   = '0;
        sh_dir     = DIR_LEFT;
        if (grant[0]) begin
            sh_data_in = req0_data;
            sh_shamt   = req0_shamt;
            sh_dir     = req0_dir;
        end else if (grant[1]) begin
            sh_data_in = req1_data;
            sh_shamt   = req1_shamt;
            sh_dir     = req1_dir;
        end
    end

    barrel_shifter32 #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .data_in  (sh_data_in),
        .shamt    (sh_shamt),
        .dir      (sh_dir),
        .data_out (sh_data_out)
    );

    // A new transfer takes precedence over a drain, so drain-and-refill
    // keeps valid high with the new result.
    always_comb begin
        resp0_valid_d = resp0_valid_q;
        resp0_data_d  = resp0_data_q;
        resp1_valid_d = resp1_valid_q;
        resp1_data_d  = resp1_data_q;
        if (grant[0]) begin
            resp0_valid_d = 1'b1;
            resp0_data_d  = sh_data_out;
        end else if (resp0_valid_q && resp0_ready) begin
            resp0_valid_d = 1'b0;
        end
        if (grant[1]) begin
            resp1_valid_d = 1'b1;
            resp1_data_d  = sh_data_out;
        end else if (resp1_valid_q && resp1_ready) begin
            resp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    always_comb begin
        resp0_valid = resp0_valid_q;
        resp1_valid = resp1_valid_q;
        resp0_data  = resp0_data_q;
        resp1_data  = resp1_data_q;
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed and randomized checks for shifter_arbiter.
module tb_shifter_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_dir;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        resp0_valid, resp0_ready;
    logic [31:0] resp0_data;
    logic        req1_valid, req1_ready, req1_dir;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        resp1_valid, resp1_ready;
    logic [31:0] resp1_data;

    int checks   = 0;
    int failures = 0;

    shifter_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_shamt  (req0_shamt),
        .req0_dir    (req0_dir),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_shamt  (req1_shamt),
        .req1_dir    (req1_dir),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic dr);
        return dr ? (d >> s) : (d << s);
    endfunction

    task automatic set_req0(input logic v, input logic [31:0] d, input logic [4:0] s, input logic dr);
        req0_valid = v; req0_data = d; req0_shamt = s; req0_dir = dr;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] d, input logic [4:0] s, input logic dr);
        req1_valid = v; req1_data = d; req1_shamt = s; req1_dir = dr;
    endtask

    // Reference model state for the random phase
    logic        mv0, mv1, mpri;
    logic [31:0] md0, md1;
    int          xfer0, xfer1, take0, take1;

    initial begin
        reset = 1'b1;
        set_req0(1'b0, 32'h0, 5'd0, 1'b0);
        set_req1(1'b0, 32'h0, 5'd0, 1'b0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // Reset state, and no ready while reset is high even with requests
        #12;
        check("rst_v0", {31'b0, resp0_valid}, 32'h0);
        check("rst_v1", {31'b0, resp1_valid}, 32'h0);
        check("rst_d0", resp0_data, 32'h0);
        check("rst_d1", resp1_data, 32'h0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_rdy0", {31'b0, req0_ready}, 32'h0);
        check("rst_rdy1", {31'b0, req1_ready}, 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;

        // Single requester: left then right, with drain-and-refill in between
        resp0_ready = 1'b1;
        set_req0(1'b1, 32'h1, 5'd31, 1'b0);
        #1;
        check("single_rdy0", {31'b0, req0_ready}, 32'h1);
        tick();
        set_req0(1'b1, 32'h4, 5'd1, 1'b1);
        check("single_v0", {31'b0, resp0_valid}, 32'h1);
        check("single_left", resp0_data, 32'h80000000);
        #1;
        check("refill_rdy0", {31'b0, req0_ready}, 32'h1);
        tick();
        check("single_right", resp0_data, 32'h2);
        req0_valid = 1'b0;
        tick();
        check("drain_v0", {31'b0, resp0_valid}, 32'h0);
        // Two grants to 0 leave pri at PRI1

        // Contention: grants alternate starting with requester 1
        resp1_ready = 1'b1;
        set_req0(1'b1, 32'hF0, 5'd0, 1'b0);
        set_req1(1'b1, 32'hF0, 5'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_rdy0_%0d", i), {31'b0, req0_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
            check($sformatf("cont_rdy1_%0d", i), {31'b0, req1_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            tick();
            if (i % 2 == 0) check($sformatf("cont_d1_%0d", i), resp1_data, 32'hF);
            else            check($sformatf("cont_d0_%0d", i), resp0_data, 32'hF0);
        end
        // Now resp0 holds F0, resp1 empty, pri = PRI1

        // Backpressure on buffer 0: req1 takes every slot
        resp0_ready = 1'b0;
        set_req0(1'b1, 32'h3, 5'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_req1(1'b1, 32'h80000000 >> i, 5'd31 - 5'(i), 1'b1);
            #1;
            check($sformatf("bp_rdy0_%0d", i), {31'b0, req0_ready}, 32'h0);
            check($sformatf("bp_rdy1_%0d", i), {31'b0, req1_ready}, 32'h1);
            tick();
            check($sformatf("bp_v0_%0d", i), {31'b0, resp0_valid}, 32'h1);
            check($sformatf("bp_d0_%0d", i), resp0_data, 32'hF0);
            check($sformatf("bp_d1_%0d", i), resp1_data, 32'h1);
        end
        // pri = PRI0; releasing backpressure drains and refills buffer 0
        resp0_ready = 1'b1;
        #1;
        check("bp_release_rdy0", {31'b0, req0_ready}, 32'h1);
        tick();
        check("bp_refill_v0", {31'b0, resp0_valid}, 32'h1);
        check("bp_refill_d0", resp0_data, 32'hC);

        // Fill both buffers, ending with a grant to 0 so pri = PRI1
        resp1_ready = 1'b0;
        tick();                       // pri PRI1 tie -> grant 1, resp0 drains
        check("fill_v1", {31'b0, resp1_valid}, 32'h1);
        check("fill_v0_drained", {31'b0, resp0_valid}, 32'h0);
        resp0_ready = 1'b0;
        #1;
        check("fill_rdy0", {31'b0, req0_ready}, 32'h1);
        tick();                       // grant 0
        check("full_v0", {31'b0, resp0_valid}, 32'h1);
        check("full_v1", {31'b0, resp1_valid}, 32'h1);
        check("full_rdy0", {31'b0, req0_ready}, 32'h0);
        check("full_rdy1", {31'b0, req1_ready}, 32'h0);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("async_v0", {31'b0, resp0_valid}, 32'h0);
        check("async_v1", {31'b0, resp1_valid}, 32'h0);
        check("async_d0", resp0_data, 32'h0);
        tick();
        reset = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #1;
        check("post_rst_rdy0", {31'b0, req0_ready}, 32'h1);
        check("post_rst_rdy1", {31'b0, req1_ready}, 32'h0);
        tick();
        check("post_rst_d0", resp0_data, 32'hC);
        check("post_rst_v1", {31'b0, resp1_valid}, 32'h0);

        // Random phase against a reference model
        reset = 1'b1;
        set_req0(1'b0, 32'h0, 5'd0, 1'b0);
        set_req1(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        mv0 = 1'b0; mv1 = 1'b0; md0 = '0; md1 = '0; mpri = 1'b0;
        xfer0 = 0; xfer1 = 0; take0 = 0; take1 = 0;
        for (int c = 0; c < 3000; c++) begin
            logic e0, e1, g0, g1;
            set_req0($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            set_req1($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            resp0_ready = $urandom_range(0, 2) != 0;
            resp1_ready = $urandom_range(0, 2) != 0;
            #1;
            check("rnd_v0", {31'b0, resp0_valid}, {31'b0, mv0});
            check("rnd_v1", {31'b0, resp1_valid}, {31'b0, mv1});
            if (mv0) check("rnd_d0", resp0_data, md0);
            if (mv1) check("rnd_d1", resp1_data, md1);
            e0 = req0_valid && (!mv0 || resp0_ready);
            e1 = req1_valid && (!mv1 || resp1_ready);
            g0 = e0 && (!e1 || !mpri);
            g1 = e1 && (!e0 || mpri);
            check("rnd_rdy0", {31'b0, req0_ready}, {31'b0, g0});
            check("rnd_rdy1", {31'b0, req1_ready}, {31'b0, g1});
            if (mv0 && resp0_ready) take0++;
            if (mv1 && resp1_ready) take1++;
            if (g0) begin
                mv0 = 1'b1; md0 = ref_shift(req0_data, req0_shamt, req0_dir); xfer0++; mpri = 1'b1;
            end else if (mv0 && resp0_ready) begin
                mv0 = 1'b0;
            end
            if (g1) begin
                mv1 = 1'b1; md1 = ref_shift(req1_data, req1_shamt, req1_dir); xfer1++; mpri = 1'b0;
            end else if (mv1 && resp1_ready) begin
                mv1 = 1'b0;
            end
            tick();
        end
        // Every accepted request is either consumed or still buffered
        check("count0", 32'(take0 + (resp0_valid ? 1 : 0)), 32'(xfer0));
        check("count1", 32'(take1 + (resp1_valid ? 1 : 0)), 32'(xfer1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
